// File: rtl/key_conditioner_pkg.sv
// Shared types and constants for the pushbutton/switch conditioning path.
package key_conditioner_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DELAY,
        ST_REPEAT
    } repeatState_t;

    localparam int SYNC_STAGES = 2;

    function automatic int maxOf(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/key_channel.sv
// One input channel: synchroniser, counter debounce, press/release pulses and
// an optional auto-repeat state machine.
module key_channel
    import key_conditioner_pkg::*;
#(
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter bit REPEAT_EN       = 1'b0
) (
    input  logic inClk,
    input  logic inRstn,
    input  logic inRaw,
    output logic outLevel,
    output logic outPress,
    output logic outRelease
);

    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RCNT_W = $clog2(maxOf(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RCNT_W-1:0] DELAY_LAST  = RCNT_W'(REPEAT_DELAY - 1);
    localparam logic [RCNT_W-1:0] PERIOD_LAST = RCNT_W'(REPEAT_PERIOD - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_level;
    logic                   r_press;
    logic                   r_release;
    repeatState_t           r_state;
    logic [RCNT_W-1:0]      r_rcnt;

    logic                   w_syncLvl;
    logic                   w_differ;
    logic                   w_acceptPress;
    logic                   w_acceptRelease;
    repeatState_t           w_stateNext;
    logic [RCNT_W-1:0]      w_rcntNext;
    logic                   w_pressNext;

    // Synchroniser resets to the idle pin level so a held key is seen as a fresh press.
    always_ff @(posedge inClk or negedge inRstn) begin
        if (!inRstn) begin
            r_sync <= {SYNC_STAGES{ACTIVE_LOW}};
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], inRaw};
        end
    end

    always_comb begin
        w_syncLvl       = r_sync[SYNC_STAGES-1] ^ ACTIVE_LOW;
        w_differ        = (w_syncLvl != r_level);
        w_acceptPress   = w_differ && (r_cnt == CNT_LAST) && w_syncLvl;
        w_acceptRelease = w_differ && (r_cnt == CNT_LAST) && !w_syncLvl;
    end

    always_ff @(posedge inClk or negedge inRstn) begin
        if (!inRstn) begin
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_press   <= w_pressNext;
            r_release <= w_acceptRelease;
            if (!w_differ) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= w_syncLvl;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge inClk or negedge inRstn) begin
        if (!inRstn) begin
            r_state <= ST_IDLE;
            r_rcnt  <= '0;
        end else begin
            r_state <= w_stateNext;
            r_rcnt  <= w_rcntNext;
        end
    end

    // A release acceptance leaves the press pulse at its default, so it wins over a repeat tick.
    always_comb begin
        w_stateNext = r_state;
        w_rcntNext  = r_rcnt;
        w_pressNext = w_acceptPress;
        if (REPEAT_EN) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_acceptPress) begin
                        w_stateNext = ST_DELAY;
                        w_rcntNext  = '0;
                    end
                end
                ST_DELAY: begin
                    if (w_acceptRelease) begin
                        w_stateNext = ST_IDLE;
                        w_rcntNext  = '0;
                    end else if (r_rcnt == DELAY_LAST) begin
                        w_stateNext = ST_REPEAT;
                        w_rcntNext  = '0;
                        w_pressNext = 1'b1;
                    end else begin
                        w_rcntNext = r_rcnt + RCNT_W'(1);
                    end
                end
                ST_REPEAT: begin
                    if (w_acceptRelease) begin
                        w_stateNext = ST_IDLE;
                        w_rcntNext  = '0;
                    end else if (r_rcnt == PERIOD_LAST) begin
                        w_rcntNext  = '0;
                        w_pressNext = 1'b1;
                    end else begin
                        w_rcntNext = r_rcnt + RCNT_W'(1);
                    end
                end
                default: begin
                    w_stateNext = ST_IDLE;
                    w_rcntNext  = '0;
                end
            endcase
        end
    end

    assign outLevel   = r_level;
    assign outPress   = r_press;
    assign outRelease = r_release;

endmodule

// File: rtl/key_conditioner.sv
// Conditions WIDTH raw board keys/switches into clean level and pulse outputs,
// one independent key_channel per bit.
module key_conditioner
    import key_conditioner_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter bit REPEAT_EN       = 1'b0
) (
    input  logic             inClk,
    input  logic             inRstn,
    input  logic [WIDTH-1:0] inRaw,
    output logic [WIDTH-1:0] outLevel,
    output logic [WIDTH-1:0] outPress,
    output logic [WIDTH-1:0] outRelease
);

    if (DEBOUNCE_CYCLES < 1) begin : g_badDebounce
        $error("key_conditioner: DEBOUNCE_CYCLES must be >= 1");
    end
    if (REPEAT_DELAY < 1) begin : g_badRepeatDelay
        $error("key_conditioner: REPEAT_DELAY must be >= 1");
    end
    if (REPEAT_PERIOD < 1) begin : g_badRepeatPeriod
        $error("key_conditioner: REPEAT_PERIOD must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_badSync
        $error("key_conditioner: SYNC_STAGES must be >= 2");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_channel
        key_channel #(
            .ACTIVE_LOW      (ACTIVE_LOW),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD),
            .REPEAT_EN       (REPEAT_EN)
        ) u_channel (
            .inClk      (inClk),
            .inRstn     (inRstn),
            .inRaw      (inRaw[i]),
            .outLevel   (outLevel[i]),
            .outPress   (outPress[i]),
            .outRelease (outRelease[i])
        );
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner: one instance without auto-repeat (A)
// and one with auto-repeat (B), sharing clock and reset.
module tb_key_conditioner;

    localparam int LAT = 6;

    logic       clk = 1'b0;
    logic       inRstn;
    logic [3:0] rawA, rawB;
    logic [3:0] levelA, pressA, relA;
    logic [3:0] levelB, pressB, relB;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    typedef struct {
        int         cyc;
        logic [3:0] pA, rA, lA, pB, rB, lB;
    } expEvent_t;

    expEvent_t expQ[$];
    expEvent_t monEv;

    key_conditioner #(
        .WIDTH(4), .ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(10), .REPEAT_PERIOD(3), .REPEAT_EN(1'b0)
    ) dutA (
        .inClk(clk), .inRstn(inRstn), .inRaw(rawA),
        .outLevel(levelA), .outPress(pressA), .outRelease(relA)
    );

    key_conditioner #(
        .WIDTH(4), .ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(10), .REPEAT_PERIOD(3), .REPEAT_EN(1'b1)
    ) dutB (
        .inClk(clk), .inRstn(inRstn), .inRaw(rawB),
        .outLevel(levelB), .outPress(pressB), .outRelease(relB)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic checkCount(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic expectEvent(input int c, input logic [3:0] pA, input logic [3:0] rA,
                               input logic [3:0] lA, input logic [3:0] pB,
                               input logic [3:0] rB, input logic [3:0] lB);
        expQ.push_back('{c, pA, rA, lA, pB, rB, lB});
    endtask

    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b);
        rawA = a;
        rawB = b;
    endtask

    task automatic waitUntil(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Any pulse on either instance is an output event that must match the next expected entry.
    always @(negedge clk) begin
        if (inRstn) begin
            while (expQ.size() > 0 && expQ[0].cyc < cyc) begin
                monEv = expQ.pop_front();
                total++;
                bad++;
                $display("[TB] FAIL missedEvent: expected at cycle %0d, still pending at cycle %0d",
                         monEv.cyc, cyc);
            end
            if ((pressA | relA | pressB | relB) != 4'b0000) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpectedEvent: cycle %0d pressA=%b relA=%b pressB=%b relB=%b",
                             cyc, pressA, relA, pressB, relB);
                end else begin
                    monEv = expQ.pop_front();
                    checkCount("eventCycle", cyc, monEv.cyc);
                    checkOutput("pressA", pressA, monEv.pA);
                    checkOutput("releaseA", relA, monEv.rA);
                    checkOutput("levelA", levelA, monEv.lA);
                    checkOutput("pressB", pressB, monEv.pB);
                    checkOutput("releaseB", relB, monEv.rB);
                    checkOutput("levelB", levelB, monEv.lB);
                end
            end
        end
    end

    initial begin
        int base;
        inRstn = 1'b1;
        applyStimulus(4'b0000, 4'b1111);
        #1 inRstn = 1'b0;
        #1;
        checkOutput("asyncResetLevelA", levelA, 4'b0000);
        checkOutput("asyncResetPressA", pressA, 4'b0000);
        checkOutput("asyncResetReleaseA", relA, 4'b0000);
        repeat (3) @(negedge clk);
        checkOutput("heldResetLevelA", levelA, 4'b0000);
        checkOutput("heldResetPressA", pressA, 4'b0000);

        // All keys held through reset: accepted as presses after release.
        inRstn = 1'b1;
        base = cyc;
        expectEvent(base + LAT, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
        waitUntil(base + LAT - 1);
        checkOutput("levelBeforeAccept", levelA, 4'b0000);
        waitUntil(base + LAT + 1);
        checkOutput("pressOneCycle", pressA, 4'b0000);
        checkOutput("levelAfterAccept", levelA, 4'b1111);

        applyStimulus(4'b1111, 4'b1111);
        base = cyc;
        expectEvent(base + LAT, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        waitUntil(base + LAT + 4);

        // Clean press then release on channel 0.
        applyStimulus(4'b1110, 4'b1111);
        base = cyc;
        expectEvent(base + LAT, 4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        waitUntil(base + LAT + 10);
        checkOutput("heldLevelA", levelA, 4'b0001);
        applyStimulus(4'b1111, 4'b1111);
        base = cyc;
        expectEvent(base + LAT, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        waitUntil(base + LAT + 4);

        // Three-cycle glitch on channel 1 is rejected.
        applyStimulus(4'b1101, 4'b1111);
        base = cyc;
        waitUntil(base + 3);
        applyStimulus(4'b1111, 4'b1111);
        waitUntil(base + 12);
        checkOutput("glitchLevelA", levelA, 4'b0000);

        // Four-cycle pulse on channel 2 is exactly long enough to be accepted.
        applyStimulus(4'b1011, 4'b1111);
        base = cyc;
        expectEvent(base + LAT, 4'b0100, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
        expectEvent(base + 4 + LAT, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        waitUntil(base + 4);
        applyStimulus(4'b1111, 4'b1111);
        waitUntil(base + 20);

        // Auto-repeat on B channel 2: press, repeats at +10 then every 3, release stops it.
        applyStimulus(4'b1111, 4'b1011);
        base = cyc;
        expectEvent(base + LAT, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0100);
        for (int k = 0; k < 7; k++) begin
            expectEvent(base + 16 + 3 * k, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0100);
        end
        expectEvent(base + 36, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0000);
        waitUntil(base + 30);
        applyStimulus(4'b1111, 4'b1111);
        waitUntil(base + 50);
        checkOutput("repeatStoppedLevelB", levelB, 4'b0000);

        // Release acceptance lands on a repeat tick: release wins.
        applyStimulus(4'b1111, 4'b0111);
        base = cyc;
        expectEvent(base + LAT, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b1000);
        expectEvent(base + 16, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b1000);
        expectEvent(base + 19, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b1000);
        expectEvent(base + 22, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000);
        waitUntil(base + 16);
        applyStimulus(4'b1111, 4'b1111);
        waitUntil(base + 35);

        // Reset in the middle of repeating, key still held afterwards.
        applyStimulus(4'b1111, 4'b1101);
        base = cyc;
        expectEvent(base + LAT, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0010);
        expectEvent(base + 16, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0010);
        expectEvent(base + 19, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0010);
        waitUntil(base + 20);
        #2 inRstn = 1'b0;
        #1;
        checkOutput("midRepeatResetLevelB", levelB, 4'b0000);
        checkOutput("midRepeatResetPressB", pressB, 4'b0000);
        checkOutput("midRepeatResetReleaseB", relB, 4'b0000);
        repeat (3) @(negedge clk);
        inRstn = 1'b1;
        base = cyc;
        expectEvent(base + LAT, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0010);
        expectEvent(base + 16, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0010);
        expectEvent(base + 19, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0010);
        expectEvent(base + 22, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0010);
        expectEvent(base + 25, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0010);
        expectEvent(base + 26, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000);
        waitUntil(base + 20);
        applyStimulus(4'b1111, 4'b1111);
        waitUntil(base + 40);

        checkCount("pendingEvents", expQ.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
